// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   state_t  - arbiter FSM state encoding (IDLE, ADDR, RESP)
//   owner_t  - identifies which requester owns the outstanding transaction
// Optional feature macro used by the design: MEM_ARB_RR_EN (round-robin pick).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef logic owner_t;

    localparam owner_t OWN_I = 1'b0;
    localparam owner_t OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, data port and shared memory channel.
//   slave  - arbiter side (consumes requests, drives grants/responses/memory request)
//   master - environment side (requesters plus memory model)
// Optional feature macro used by the design: MEM_ARB_RR_EN (no effect on this file).
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    // Instruction-fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    // Data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    // Shared memory channel
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_ready;
    logic              m_rvalid;
    logic [31:0]       m_rdata;
    // Status
    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  m_ready, m_rvalid, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_wstrb, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
        output m_ready, m_rvalid, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between fetch and data requests.
//   i_req, d_req - pending requests
//   last_served  - owner of the most recent grant (only with MEM_ARB_RR_EN)
//   valid        - at least one request pending
//   winner       - OWN_I or OWN_D
// MEM_ARB_RR_EN defined: on a tie the requester not served last wins.
// MEM_ARB_RR_EN undefined: fixed priority, data wins over fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
`ifdef MEM_ARB_RR_EN
    input  owner_t last_served,
`endif
    output logic   valid,
    output owner_t winner
);

    always_comb begin
        valid  = i_req | d_req;
        winner = d_req ? OWN_D : OWN_I;
`ifdef MEM_ARB_RR_EN
        if (i_req && d_req) begin
            winner = (last_served == OWN_D) ? OWN_I : OWN_D;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a data port onto one memory channel,
// one transaction outstanding at a time.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - mem_arbiter_if.slave: fetch/data request ports, memory channel, busy
// Optional feature macro: MEM_ARB_RR_EN selects round-robin instead of
// fixed data-over-fetch priority on simultaneous requests.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_t            state_q;
    owner_t            owner_q;
    logic              m_req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
`ifdef MEM_ARB_RR_EN
    owner_t            last_q;
`endif

    logic   pick_valid;
    owner_t pick_owner;
    logic   take;

    mem_arb_pick u_pick (
        .i_req       (bus.i_req),
        .d_req       (bus.d_req),
`ifdef MEM_ARB_RR_EN
        .last_served (last_q),
`endif
        .valid       (pick_valid),
        .winner      (pick_owner)
    );

    // Grants are only issued while idle; requests seen in ADDR/RESP just wait.
    assign take = (state_q == IDLE) && pick_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            m_req_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q  <= OWN_I;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (take) begin
                        owner_q <= pick_owner;
                        m_req_q <= 1'b1;
                        state_q <= ADDR;
`ifdef MEM_ARB_RR_EN
                        last_q  <= pick_owner;
`endif
                        if (pick_owner == OWN_D) begin
                            we_q    <= bus.d_we;
                            addr_q  <= bus.d_addr;
                            wdata_q <= bus.d_wdata;
                            wstrb_q <= bus.d_wstrb;
                        end else begin
                            // Fetches are always reads.
                            we_q    <= 1'b0;
                            addr_q  <= bus.i_addr;
                            wdata_q <= '0;
                            wstrb_q <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (bus.m_ready) begin
                        m_req_q <= 1'b0;
                        state_q <= we_q ? IDLE : RESP;
                    end
                end
                RESP: begin
                    if (bus.m_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    m_req_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_gnt    = take && (pick_owner == OWN_I);
    assign bus.d_gnt    = take && (pick_owner == OWN_D);

    // Read data passes straight through; only the owner's rvalid qualifies it.
    assign bus.i_rvalid = (state_q == RESP) && bus.m_rvalid && (owner_q == OWN_I);
    assign bus.d_rvalid = (state_q == RESP) && bus.m_rvalid && (owner_q == OWN_D);
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

    assign bus.m_req    = m_req_q;
    assign bus.m_we     = we_q;
    assign bus.m_addr   = addr_q;
    assign bus.m_wdata  = wdata_q;
    assign bus.m_wstrb  = wstrb_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a transaction-level
// reference model checked every cycle, plus literal expectations per scenario.
// Honours MEM_ARB_RR_EN to select the expected arbitration order.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a grant; leaves the caller at the granting negedge.
    task automatic wait_gnt(input string name, output logic is_d);
        logic found;
        found = 1'b0;
        is_d  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.i_gnt || bus.d_gnt) begin
                is_d  = bus.d_gnt;
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: no grant within 20 cycles, expected one", name);
        end
    endtask

    // Reference model: one outstanding-transaction record. The values held here
    // describe the arbiter as it will be after the next rising edge.
    logic        md_busy   = 1'b0;
    logic        md_issued = 1'b0;
    logic        md_own_d  = 1'b0;
    logic        md_we     = 1'b0;
    logic [31:0] md_addr   = '0;
    logic [31:0] md_wdata  = '0;
    logic [3:0]  md_wstrb  = '0;
    logic        md_last_d = 1'b0;

    initial begin : model
        logic any;
        logic win_d;
        forever begin
            @(negedge clk);
            chk32("i_rdata_passthru", bus.i_rdata, bus.m_rdata);
            chk32("d_rdata_passthru", bus.d_rdata, bus.m_rdata);
            if (rst) begin
                md_busy = 1'b0; md_issued = 1'b0; md_own_d = 1'b0; md_we = 1'b0;
                md_addr = '0; md_wdata = '0; md_wstrb = '0; md_last_d = 1'b0;
                chk1("rst_busy", bus.busy, 1'b0);
                chk1("rst_m_req", bus.m_req, 1'b0);
                chk1("rst_i_gnt", bus.i_gnt, 1'b0);
                chk1("rst_d_gnt", bus.d_gnt, 1'b0);
                chk1("rst_i_rvalid", bus.i_rvalid, 1'b0);
                chk1("rst_d_rvalid", bus.d_rvalid, 1'b0);
                chk1("rst_m_we", bus.m_we, 1'b0);
                chk32("rst_m_addr", bus.m_addr, 32'h0);
                chk32("rst_m_wdata", bus.m_wdata, 32'h0);
                chk32("rst_m_wstrb", {28'h0, bus.m_wstrb}, 32'h0);
            end else if (!md_busy) begin
                any = bus.i_req | bus.d_req;
                if (bus.i_req && bus.d_req) win_d = RR_EN ? !md_last_d : 1'b1;
                else                        win_d = bus.d_req;
                chk1("idle_i_gnt", bus.i_gnt, any && !win_d);
                chk1("idle_d_gnt", bus.d_gnt, any && win_d);
                chk1("idle_m_req", bus.m_req, 1'b0);
                chk1("idle_busy", bus.busy, 1'b0);
                chk1("idle_i_rvalid", bus.i_rvalid, 1'b0);
                chk1("idle_d_rvalid", bus.d_rvalid, 1'b0);
                if (any) begin
                    md_busy = 1'b1; md_issued = 1'b0; md_own_d = win_d; md_last_d = win_d;
                    if (win_d) begin
                        md_we = bus.d_we; md_addr = bus.d_addr;
                        md_wdata = bus.d_wdata; md_wstrb = bus.d_wstrb;
                    end else begin
                        md_we = 1'b0; md_addr = bus.i_addr; md_wdata = '0; md_wstrb = '0;
                    end
                end
            end else if (!md_issued) begin
                chk1("addr_m_req", bus.m_req, 1'b1);
                chk1("addr_busy", bus.busy, 1'b1);
                chk1("addr_i_gnt", bus.i_gnt, 1'b0);
                chk1("addr_d_gnt", bus.d_gnt, 1'b0);
                chk1("addr_i_rvalid", bus.i_rvalid, 1'b0);
                chk1("addr_d_rvalid", bus.d_rvalid, 1'b0);
                chk1("addr_m_we", bus.m_we, md_we);
                chk32("addr_m_addr", bus.m_addr, md_addr);
                chk32("addr_m_wstrb", {28'h0, bus.m_wstrb}, {28'h0, md_wstrb});
                if (md_we) chk32("addr_m_wdata", bus.m_wdata, md_wdata);
                if (bus.m_ready) begin
                    if (md_we) md_busy = 1'b0;
                    else       md_issued = 1'b1;
                end
            end else begin
                chk1("resp_m_req", bus.m_req, 1'b0);
                chk1("resp_busy", bus.busy, 1'b1);
                chk1("resp_i_gnt", bus.i_gnt, 1'b0);
                chk1("resp_d_gnt", bus.d_gnt, 1'b0);
                chk1("resp_i_rvalid", bus.i_rvalid, bus.m_rvalid && !md_own_d);
                chk1("resp_d_rvalid", bus.d_rvalid, bus.m_rvalid && md_own_d);
                if (bus.m_rvalid) md_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic who;
        logic [3:0] seq;
        logic [3:0] exp_seq;
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
        bus.m_ready = 0; bus.m_rvalid = 0; bus.m_rdata = '0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        step();

        // Fetch read at minimum latency.
        bus.i_req = 1; bus.i_addr = 32'h0000_1000; bus.m_ready = 1;
        @(negedge clk); chk1("t1_i_gnt", bus.i_gnt, 1'b1);
        step(); bus.i_req = 0;
        @(negedge clk); chk1("t1_m_req", bus.m_req, 1'b1);
        chk32("t1_m_addr", bus.m_addr, 32'h0000_1000);
        step(); bus.m_rvalid = 1; bus.m_rdata = 32'hDEAD_BEEF;
        @(negedge clk); chk1("t1_i_rvalid", bus.i_rvalid, 1'b1);
        chk32("t1_i_rdata", bus.i_rdata, 32'hDEAD_BEEF);
        step(); bus.m_rvalid = 0; bus.m_ready = 0;
        @(negedge clk); chk1("t1_busy_after", bus.busy, 1'b0);
        step();

        // Data write with memory stalling three cycles.
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h0000_2000;
        bus.d_wdata = 32'h1234_5678; bus.d_wstrb = 4'b0011;
        @(negedge clk); chk1("t2_d_gnt", bus.d_gnt, 1'b1);
        step(); bus.d_req = 0; bus.d_we = 0; bus.d_wdata = '0; bus.d_wstrb = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk1("t2_m_req_stall", bus.m_req, 1'b1);
            chk32("t2_m_wdata", bus.m_wdata, 32'h1234_5678);
            step();
        end
        bus.m_ready = 1;
        @(negedge clk); chk1("t2_m_req_last", bus.m_req, 1'b1);
        chk32("t2_m_wstrb", {28'h0, bus.m_wstrb}, 32'h3);
        step(); bus.m_ready = 0;
        @(negedge clk); chk1("t2_busy_drop", bus.busy, 1'b0);
        chk1("t2_no_d_rvalid", bus.d_rvalid, 1'b0);
        step();

        // Simultaneous requests, data drops after its grant.
        rst = 1; step(); rst = 0;
        bus.i_req = 1; bus.i_addr = 32'h100; bus.d_req = 1; bus.d_addr = 32'h200;
        bus.m_ready = 1; bus.m_rvalid = 1; bus.m_rdata = 32'h55;
        wait_gnt("t3a_first", who); chk1("t3a_first_is_d", who, 1'b1);
        step(); bus.d_req = 0;
        wait_gnt("t3a_second", who); chk1("t3a_second_is_i", who, 1'b0);
        step(); bus.i_req = 0;
        repeat (3) step();

        // Both held for four grants.
        rst = 1; step(); rst = 0;
        bus.i_req = 1; bus.d_req = 1;
        exp_seq = RR_EN ? 4'b0101 : 4'b1111;  // bit g = grant g went to data
        seq = '0;
        for (int g = 0; g < 4; g++) begin
            wait_gnt("t3b_gnt", who);
            seq[g] = who;
            step();
        end
        chk32("t3b_order", {28'h0, seq}, {28'h0, exp_seq});
        bus.i_req = 0; bus.d_req = 0;
        repeat (3) step();
        bus.m_rvalid = 0; bus.m_ready = 0;
        step();

        // Spurious m_rvalid in IDLE and ADDR.
        bus.m_rvalid = 1;
        @(negedge clk); chk1("t4_idle_i_rvalid", bus.i_rvalid, 1'b0);
        chk1("t4_idle_d_rvalid", bus.d_rvalid, 1'b0);
        step(); bus.i_req = 1; bus.i_addr = 32'h40;
        @(negedge clk); chk1("t4_i_gnt", bus.i_gnt, 1'b1);
        step(); bus.i_req = 0;
        @(negedge clk); chk1("t4_addr_i_rvalid", bus.i_rvalid, 1'b0);
        step(); bus.m_ready = 1;
        @(negedge clk); chk1("t4_hs_i_rvalid", bus.i_rvalid, 1'b0);
        step(); bus.m_ready = 0;
        @(negedge clk); chk1("t4_resp_i_rvalid", bus.i_rvalid, 1'b1);
        step(); bus.m_rvalid = 0;
        step();

        // Reset during RESP abandons the read.
        bus.i_req = 1; bus.i_addr = 32'h3000; bus.m_ready = 1;
        @(negedge clk); chk1("t5_i_gnt", bus.i_gnt, 1'b1);
        step(); bus.i_req = 0;
        @(negedge clk);
        step(); bus.m_ready = 0;
        @(negedge clk); chk1("t5_busy_resp", bus.busy, 1'b1);
        step(); rst = 1;
        @(negedge clk); chk1("t5_rst_busy", bus.busy, 1'b0);
        chk1("t5_rst_m_req", bus.m_req, 1'b0);
        step(); rst = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h0000_0BAD;
        @(negedge clk); chk1("t5_late_i_rvalid", bus.i_rvalid, 1'b0);
        chk1("t5_late_d_rvalid", bus.d_rvalid, 1'b0);
        step(); bus.m_rvalid = 0; bus.i_req = 1; bus.i_addr = 32'h3000;
        wait_gnt("t5_regrant", who); chk1("t5_regrant_is_i", who, 1'b0);
        step(); bus.i_req = 0; bus.m_ready = 1;
        @(negedge clk); chk32("t5_m_addr", bus.m_addr, 32'h3000);
        step(); bus.m_ready = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h0000_600D;
        @(negedge clk); chk1("t5_i_rvalid", bus.i_rvalid, 1'b1);
        chk32("t5_i_rdata", bus.i_rdata, 32'h0000_600D);
        step(); bus.m_rvalid = 0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
